// File: rtl/regfile_sb.sv
// Multi-port register file (two write ports, two read ports) with a per-register
// pending-write scoreboard for hazard detection. Optional bypass: REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int DATA_W = 64,
   parameter int NREGS  = 15,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 2
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [ADDR_W-1:0]       dstE,
   input  logic [DATA_W-1:0]       valE,
   input  logic [ADDR_W-1:0]       dstM,
   input  logic [DATA_W-1:0]       valM,
   input  logic [ADDR_W-1:0]       srcA,
   input  logic [ADDR_W-1:0]       srcB,
   output logic [DATA_W-1:0]       valA,
   output logic [DATA_W-1:0]       valB,
   output logic                    busyA,
   output logic                    busyB,
   input  logic                    Issue,
   input  logic [ADDR_W-1:0]       IssueE,
   input  logic [ADDR_W-1:0]       IssueM,
   output logic                    IssueOk,
   input  logic                    Flush,
   output logic [NREGS*DATA_W-1:0] RegsFlat
);

   localparam logic [ADDR_W-1:0] NREGS_IDX = ADDR_W'(NREGS);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [CNT_W-1:0]  cnt_q  [NREGS];
   logic [CNT_W-1:0]  cnt_d  [NREGS];

   logic             we_e, we_m, ie_v, im_v;
   logic             issue_blocked;
   logic [NREGS-1:0] dec, iss_hit, inc;

   // Issue handshake: decode presents Issue with IssueE/IssueM; the issue is taken
   // on the edge where Issue && IssueOk. IssueOk depends on the current counters and
   // this cycle's write-back indices, so decode holds Issue until it is accepted.
   always_comb begin
      we_e          = dstE < NREGS_IDX;
      we_m          = dstM < NREGS_IDX;
      ie_v          = IssueE < NREGS_IDX;
      im_v          = IssueM < NREGS_IDX;
      dec           = '0;
      iss_hit       = '0;
      inc           = '0;
      issue_blocked = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         dec[i]     = (we_e && dstE == ADDR_W'(i)) || (we_m && dstM == ADDR_W'(i));
         iss_hit[i] = (ie_v && IssueE == ADDR_W'(i)) || (im_v && IssueM == ADDR_W'(i));
         // A full counter only stalls issue if write-back is not draining it now.
         if (iss_hit[i] && cnt_q[i] == CNT_MAX && !dec[i]) begin
            issue_blocked = 1'b1;
         end
      end
      IssueOk = !(Issue && issue_blocked);
      for (int i = 0; i < NREGS; i++) begin
         inc[i] = Issue && IssueOk && iss_hit[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (we_m && dstM == ADDR_W'(i)) begin
            regs_d[i] = valM;
         end else if (we_e && dstE == ADDR_W'(i)) begin
            regs_d[i] = valE;
         end

         cnt_d[i] = cnt_q[i];
         if (Flush) begin
            cnt_d[i] = '0;
         end else if (inc[i] && !dec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec[i] && !inc[i] && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   always_comb begin
      valA  = '0;
      valB  = '0;
      busyA = 1'b0;
      busyB = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (srcA == ADDR_W'(i)) begin
            valA  = regs_q[i];
            busyA = cnt_q[i] != '0;
         end
         if (srcB == ADDR_W'(i)) begin
            valB  = regs_q[i];
            busyB = cnt_q[i] != '0;
         end
      end
`ifdef REGFILE_BYPASS_EN
      // A matching dst implies a valid dst because srcX is already in range here.
      if (srcA < NREGS_IDX) begin
         if (srcA == dstM) begin
            valA = valM;
         end else if (srcA == dstE) begin
            valA = valE;
         end
         if (srcA == dstM || srcA == dstE) begin
            busyA = 1'b0;
         end
      end
      if (srcB < NREGS_IDX) begin
         if (srcB == dstM) begin
            valB = valM;
         end else if (srcB == dstE) begin
            valB = valE;
         end
         if (srcB == dstM || srcB == dstE) begin
            busyB = 1'b0;
         end
      end
`endif
   end

   always_comb begin
      RegsFlat = '0;
      for (int i = 0; i < NREGS; i++) begin
         RegsFlat[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed plan then random traffic, checked by a scoreboard
// queue filled from an array-based reference model.
module tb_regfile_sb;

   localparam int DATA_W = 64;
   localparam int NREGS  = 15;
   localparam int ADDR_W = 4;
   localparam int CNT_W  = 2;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam int FW     = NREGS * DATA_W;
   localparam int W      = 2 * DATA_W + 3 + FW;

   logic              Clk;
   logic              Reset;
   logic [ADDR_W-1:0] dstE, dstM, srcA, srcB, IssueE, IssueM;
   logic [DATA_W-1:0] valE, valM, valA, valB;
   logic              busyA, busyB, Issue, IssueOk, Flush;
   logic [FW-1:0]     RegsFlat;

   regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset),
      .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
      .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
      .busyA(busyA), .busyB(busyB),
      .Issue(Issue), .IssueE(IssueE), .IssueM(IssueM), .IssueOk(IssueOk),
      .Flush(Flush), .RegsFlat(RegsFlat)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   // reference model
   logic [DATA_W-1:0] m_regs [NREGS];
   int                m_cnt  [NREGS];

   function automatic bit is_dst(int r);
      return r < NREGS && (r == int'(dstE) || r == int'(dstM));
   endfunction

   function automatic logic [DATA_W-1:0] m_val(int src);
      logic [DATA_W-1:0] v;
      if (src >= NREGS) return '0;
      v = m_regs[src];
`ifdef REGFILE_BYPASS_EN
      if (src == int'(dstM)) v = valM;
      else if (src == int'(dstE)) v = valE;
`endif
      return v;
   endfunction

   function automatic logic m_busy(int src);
      if (src >= NREGS) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (is_dst(src)) return 1'b0;
`endif
      return m_cnt[src] != 0;
   endfunction

   function automatic logic m_ok();
      int idx[2];
      idx[0] = int'(IssueE);
      idx[1] = int'(IssueM);
      if (!Issue) return 1'b1;
      foreach (idx[k]) begin
         if (idx[k] < NREGS && m_cnt[idx[k]] == CMAX && !is_dst(idx[k])) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic m_step(input logic ok);
      bit inc, dec;
      if (!Reset) begin
         for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
         end
         return;
      end
      for (int r = 0; r < NREGS; r++) begin
         inc = Issue && ok && (r == int'(IssueE) || r == int'(IssueM));
         dec = is_dst(r);
         if (Flush) m_cnt[r] = 0;
         else if (inc && !dec) m_cnt[r] = m_cnt[r] + 1;
         else if (dec && !inc && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
      end
      if (int'(dstE) < NREGS) m_regs[dstE] = valE;
      if (int'(dstM) < NREGS) m_regs[dstM] = valM;
   endtask

   // driver: apply a cycle's inputs at negedge, queue the expected outputs, advance model
   task automatic drive(input bit rst_n, input bit chk,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input bit iss, input logic [3:0] ie, input logic [3:0] im,
                        input bit fl);
      logic [FW-1:0] flat;
      logic          ok;
      @(negedge Clk);
      Reset = rst_n; dstE = de; valE = ve; dstM = dm; valM = vm;
      srcA = sa; srcB = sb; Issue = iss; IssueE = ie; IssueM = im; Flush = fl;
      ok = m_ok();
      if (chk) begin
         for (int r = 0; r < NREGS; r++) flat[r*DATA_W +: DATA_W] = m_regs[r];
         exp_q.push_back({m_val(int'(sa)), m_val(int'(sb)), m_busy(int'(sa)),
                          m_busy(int'(sb)), ok, flat});
      end
      @(posedge Clk);
      m_step(ok);
   endtask

   task automatic idle(input logic [3:0] sa, input logic [3:0] sb);
      drive(1, 1, 4'hF, 64'h0, 4'hF, 64'h0, sa, sb, 0, 4'hF, 4'hF, 0);
   endtask

   // scoreboard monitor
   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge Clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("valA", valA, e[FW+3+DATA_W +: DATA_W]);
            cmp("valB", valB, e[FW+3 +: DATA_W]);
            cmp("busyA", 64'(busyA), 64'(e[FW+2]));
            cmp("busyB", 64'(busyB), 64'(e[FW+1]));
            cmp("IssueOk", 64'(IssueOk), 64'(e[FW]));
            for (int r = 0; r < NREGS; r++) begin
               cmp($sformatf("RegsFlat_r%0d", r), RegsFlat[r*DATA_W +: DATA_W],
                   e[r*DATA_W +: DATA_W]);
            end
         end
      end
   end

   function automatic logic [3:0] rnd_idx();
      int r;
      r = $urandom_range(0, 9);
      if (r >= 8) return 4'hF;
      if (r == 7) return 4'(NREGS - 1);
      return 4'($urandom_range(0, 5));
   endfunction

   initial begin
      // reset for two cycles; first edge leaves state unknown, so not checked
      drive(0, 0, 4'hF, 0, 4'hF, 0, 0, 0, 0, 4'hF, 4'hF, 0);
      drive(0, 1, 4'hF, 0, 4'hF, 0, 0, 1, 0, 4'hF, 4'hF, 0);
      idle(0, 0);
      // E/M collision on the same register: M wins; RNONE write ignored
      drive(1, 1, 4'd2, 64'h11, 4'd2, 64'h22, 2, 2, 0, 4'hF, 4'hF, 0);
      idle(2, 0);
      drive(1, 1, 4'hF, 64'h33, 4'hF, 0, 2, 3, 0, 4'hF, 4'hF, 0);
      idle(2, 4'hF);
      // issue with identical E/M index counts once; writeback clears it
      drive(1, 1, 4'hF, 0, 4'hF, 0, 3, 3, 1, 4'd3, 4'd3, 0);
      drive(1, 1, 4'd3, 64'h5, 4'hF, 0, 3, 3, 0, 4'hF, 4'hF, 0);
      idle(3, 3);
      // fill reg 1 to the counter limit, then stall, then drain-and-issue
      repeat (3) drive(1, 1, 4'hF, 0, 4'hF, 0, 1, 1, 1, 4'd1, 4'hF, 0);
      drive(1, 1, 4'hF, 0, 4'hF, 0, 1, 0, 1, 4'd1, 4'hF, 0);
      drive(1, 1, 4'hF, 0, 4'd1, 64'h99, 1, 0, 1, 4'd1, 4'hF, 0);
      idle(1, 0);
      // flush with a concurrent write, then reset with a concurrent write
      drive(1, 1, 4'hF, 0, 4'hF, 0, 0, 5, 1, 4'd0, 4'd5, 0);
      drive(1, 1, 4'hF, 0, 4'hF, 0, 0, 5, 1, 4'd0, 4'hF, 0);
      drive(1, 1, 4'd5, 64'h7, 4'hF, 0, 0, 5, 1, 4'd6, 4'hF, 1);
      idle(5, 1);
      drive(0, 1, 4'd6, 64'h66, 4'hF, 0, 5, 6, 1, 4'd2, 4'hF, 1);
      idle(5, 6);
      // read of a register being written this cycle while it is pending
      drive(1, 1, 4'hF, 0, 4'hF, 0, 4, 4, 1, 4'd4, 4'hF, 0);
      drive(1, 1, 4'hF, 0, 4'd4, 64'hAB, 0, 4, 0, 4'hF, 4'hF, 0);
      idle(4, 4);
      // random traffic
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 59) != 0), 1,
               rnd_idx(), {$urandom, $urandom}, rnd_idx(), {$urandom, $urandom},
               rnd_idx(), rnd_idx(), $urandom_range(0, 1), rnd_idx(), rnd_idx(),
               ($urandom_range(0, 24) == 0));
      end
      idle(0, 0);
      // bounded drain of the scoreboard
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge Clk);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file for the PIPE processor; successor to the fixed 15×64 SEQ register file.
- Provides two write ports (E and M) and two combinational read ports (A and B).
- Adds a per-register pending-write scoreboard that decode uses to detect load/use and RAW hazards, plus a flush input for mispredict and exception recovery.
- Sits between decode (reads, issue) and write-back (writes).

Parameters:
- DATA_W, 64, register width in bits.
- NREGS, 15, number of architectural registers (index 0..NREGS-1); must be ≤ 2**ADDR_W-1.
- ADDR_W, 4, register index width; index 2**ADDR_W-1 (4'hF) is RNONE.
- CNT_W, 2, width of each per-register pending-write counter; max outstanding writes per register = 2**CNT_W-1.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- dstE  in  ADDR_W  E-port write index (RNONE = no write).
- valE  in  DATA_W  E-port write data.
- dstM  in  ADDR_W  M-port write index (RNONE = no write).
- valM  in  DATA_W  M-port write data.
- srcA  in  ADDR_W  read index A.
- srcB  in  ADDR_W  read index B.
- valA  out  DATA_W  read data A.
- valB  out  DATA_W  read data B.
- busyA  out  1  srcA has an outstanding write.
- busyB  out  1  srcB has an outstanding write.
- Issue  in  1  decode issues an instruction this cycle.
- IssueE  in  ADDR_W  future dstE of the issued instruction.
- IssueM  in  ADDR_W  future dstM of the issued instruction.
- IssueOk  out  1  issue can be accepted; combinational.
- Flush  in  1  clear all pending counters.
- RegsFlat  out  NREGS*DATA_W  all registers concatenated; register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset: on a rising Clk with Reset=0, all registers and counters go to 0. Every other input is ignored that cycle, including writes, Issue and Flush. Outputs then read 0, busyA/B=0, IssueOk=1.
- Writes: registered on the rising Clk.
  - Any index ≥ NREGS, including RNONE, is ignored.
  - If dstE==dstM (not RNONE), valM wins; valE is discarded.
- Reads: combinational, zero latency.
  - Index ≥ NREGS returns 0 and busy=0.
  - Without the bypass feature, a read in the same cycle as a write to the same index returns the old value.
- Scoreboard, one counter per register:
  - Increment: Issue & IssueOk, once per valid distinct index in {IssueE, IssueM}. If IssueE==IssueM, increment once.
  - Decrement: once per valid distinct index in {dstE, dstM}. If dstE==dstM, decrement once.
  - Same register incremented and decremented in one cycle: counter unchanged.
  - Decrement at 0 saturates at 0 and is not an error.
  - busyX = (counter[srcX] != 0). It uses the current counter value, not the next one.
- IssueOk = 0 when Issue is asserted and some valid issue index has counter == 2**CNT_W-1 with no decrement of that index this cycle. Otherwise IssueOk = 1. When IssueOk = 0, no counter changes from the issue.
- Flush=1: every counter becomes 0 on the next edge, overriding issue and decrement. Register writes in the same cycle still commit.
- Reset mid-operation overrides Flush, writes and issue.
- RegsFlat reflects register state only; bypass never affects it.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - valX = valM if srcX==dstM, else valE if srcX==dstE, else the stored value. Applies only when the index is < NREGS.
  - busyX is forced to 0 when srcX matches a valid dstE/dstM in the same cycle.
- Undefined: reads return stored values only; busyX comes straight from the counter.

Test Plan:
- Reset=0 for 2 cycles, then Reset=1 → RegsFlat=0, valA=valB=0, busyA=busyB=0, IssueOk=1.
- dstE=2, valE=0x11, dstM=2, valM=0x22 for one edge; then srcA=2 → valA=0x22. Next, dstE=4'hF with valE=0x33 → RegsFlat unchanged.
- Issue=1, IssueE=3, IssueM=3; then srcA=3 → busyA=1, counter=1. Then dstE=3, valE=5 → after the edge busyA=0, valA=5.
- Issue to reg 1 three times with no writeback → counter=3, busy=1. Fourth Issue → IssueOk=0, counter stays 3. Same cycle plus dstM=1 → IssueOk=1, counter stays 3.
- Counters at r0=2, r5=1; assert Flush together with dstE=5, valE=0x7 → all busy=0, r5=0x7. Then Reset=0 with dstE=6 → r6=0, all registers 0.
- With REGFILE_BYPASS_EN: srcB=4, dstM=4, valM=0xAB, counter[4]=1 → valB=0xAB and busyB=0 in the same cycle. Without it: valB=old value, busyB=1.
